// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared types and constants for the fetch path.
//   fetch_state_t : fetch sequencer states
//   RESET_PC      : PC loaded on reset
//   FLAG_N/Z/V    : bit positions of the condition flags inside the 3-bit
//                   flag vector {V,Z,N}
//   pc_align()    : forces an incoming PC onto a halfword boundary
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam int unsigned FLAG_N = 32'd0;
    localparam int unsigned FLAG_Z = 32'd1;
    localparam int unsigned FLAG_V = 32'd2;

    // Instructions are 16-bit, so bit 0 of any PC is forced low.
    function automatic logic [15:0] pc_align(input logic [15:0] pc);
        return pc & 16'hFFFE;
    endfunction

endpackage

// File: rtl/flag_reg.sv
// ---------------------------------------------------------------------------
// flag_reg -- 3-bit condition-flag register {V,Z,N} with per-bit load enable.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, clears all flags
//   wen_i   : per-bit load enable
//   data_i  : per-bit load value
//   flags_o : registered flags
// ---------------------------------------------------------------------------
module flag_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] wen_i,
    input  logic [2:0] data_i,
    output logic [2:0] flags_o
);

    logic [2:0] flags_q;
    logic [2:0] flags_d;

    // Merge enabled bits of the new value with the held flags.
    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < 3; i++) begin
            if (wen_i[i]) begin
                flags_d[i] = data_i[i];
            end else begin
                flags_d[i] = flags_q[i];
            end
        end
    end

    // Flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- single-outstanding instruction fetch sequencer.
// Fetches one 16-bit instruction at pc_cur, holds it for decode until it is
// retired, then advances to pc_next. A retired HLT parks the unit until reset.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   pc_next                   : next PC, sampled on retire
//   pc_cur                    : address of the current instruction
//   imem_req/imem_addr        : memory request and address
//   imem_gnt                  : request accepted
//   imem_rvalid/imem_rdata    : read data return
//   instr_out/instr_valid     : buffered instruction to decode
//   instr_ready               : decode retires instr_out
//   flag_wen/flag_in/flag_out : per-bit flag update {V,Z,N}, applied on retire
//   halt_in/halted            : instr_out is HLT / core halted
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   fetch_cnt : retired instructions
//   stall_cnt : REQ without gnt, WAIT, or ISSUE without ready cycles
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_next,
    output logic [15:0] pc_cur,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [2:0]  flag_wen,
    input  logic [2:0]  flag_in,
    output logic [2:0]  flag_out,
    input  logic        halt_in,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         halted_q, halted_d;
    logic         retire_s;

    // Next-state, PC and instruction-buffer logic. The output flops are
    // loaded from the decoded next state so they line up with state_q.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else begin
                    state_d = WAIT;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (halt_in) begin
                        state_d = HALT;
                    end else begin
                        retire_s = 1'b1;
                        pc_d     = pc_align(pc_next);
                        state_d  = REQ;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        req_d    = (state_d == REQ);
        valid_d  = (state_d == ISSUE);
        halted_d = (state_d == HALT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc_cur      = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

    // Flag writes only take effect on a real (non-HLT) retire.
    flag_reg u_flag_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen_i   (flag_wen & {3{retire_s}}),
        .data_i  (flag_in),
        .flags_o (flag_out)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        stall_s;

    assign stall_s = ((state_q == REQ) && !imem_gnt) ||
                     (state_q == WAIT) ||
                     ((state_q == ISSUE) && !instr_ready);

    // Saturating retire and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (retire_s && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 fetch_unit SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 pc_next  input  16  next PC from the branch/PC-select logic, valid while instr_valid=1.
REQ-005 pc_cur  output  16  address of the instruction currently held or fetched.
REQ-006 imem_req / imem_addr  output  1/16  instruction-memory request and address (imem_addr = pc_cur).
REQ-007 imem_gnt  input  1  memory accepted the request this cycle.
REQ-008 imem_rvalid / imem_rdata  input  1/16  read-data return.
REQ-009 instr_out / instr_valid  output  16/1  buffered instruction to decode.
REQ-010 instr_ready  input  1  decode/execute retires instr_out this cycle.
REQ-011 flag_wen / flag_in  input  3/3  per-bit flag write enables and values, bit order {V,Z,N}.
REQ-012 flag_out  output  3  registered flags {V,Z,N} fed to the branch logic.
REQ-013 halt_in  input  1  instr_out decodes as HLT.
REQ-014 halted  output  1  core halted.

Function
REQ-015 The FSM SHALL have states BOOT, REQ, WAIT, ISSUE, HALT.
REQ-016 BOOT: all outputs idle; next cycle -> REQ.
REQ-017 REQ: imem_req=1; on imem_gnt -> WAIT, else remain in REQ with imem_addr held stable.
REQ-018 WAIT: imem_req=0; on imem_rvalid, capture imem_rdata into instr_out -> ISSUE.
REQ-019 imem_rvalid outside WAIT SHALL be ignored.
REQ-020 ISSUE: instr_valid=1; instr_out stable until retired.
REQ-021 Retire = ISSUE and instr_ready and !halt_in: pc_cur <= {pc_next[15:1],1'b0}, flags updated, -> REQ.
REQ-022 ISSUE and instr_ready and halt_in: -> HALT; pc_cur, flags unchanged.
REQ-023 HALT: halted=1, instr_valid=0, imem_req=0; absorbing until reset.
REQ-024 Flag bit i SHALL load flag_in[i] only on retire with flag_wen[i]=1; flag_wen outside retire ignored.
REQ-025 pc_cur wrap-around is owned by pc_next; 0xFFFE -> 0x0000 SHALL load without special handling.
REQ-026 Minimum fetch-to-retire latency: REQ (gnt same cycle) 1 + WAIT 1 + ISSUE 1 = 3 cycles.

Reset
REQ-027 On rst_n=0: state=BOOT, pc_cur=0x0000, instr_out=0x0000, instr_valid=0, imem_req=0, flag_out=3'b000, halted=0, counters 0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding fetch; late rvalid after reset SHALL be discarded per REQ-019.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN SHALL, when defined, add outputs fetch_cnt[15:0] (retires) and stall_cnt[15:0] (cycles in REQ without gnt, in WAIT, or in ISSUE without instr_ready), both saturating at 0xFFFF, cleared by reset.
REQ-030 Without FETCH_PERF_CNT_EN, those ports and registers SHALL NOT exist; all other behaviour identical.

Structure
REQ-031 Shared package cpu_pkg SHALL hold the fetch_state_t enum, RESET_PC=16'h0000, and flag indices FLAG_N=0, FLAG_Z=1, FLAG_V=2.
REQ-032 Flag storage SHALL be a sub-module flag_reg (3 bits, per-bit enable, async active-low reset).

Verification
REQ-033 Reset release, gnt tied 1, rvalid one cycle after gnt, rdata=0xA123, ready=1, pc_next=0x0002 -> instr_valid at cycle 3, pc_cur=0x0002 after retire.
REQ-034 gnt held low 4 cycles -> imem_req=1, imem_addr constant for 4 cycles, stall_cnt=4 (macro on).
REQ-035 Retire with flag_wen=3'b010, flag_in=3'b111 -> flag_out=3'b010 from 3'b000; flag_wen=3'b101 without retire -> unchanged.
REQ-036 halt_in=1 with ready -> halted=1 next cycle, imem_req stays 0 for 20 cycles, pc_cur unchanged.
REQ-037 rst_n asserted in WAIT, rvalid pulsed one cycle after release -> ignored; fetch restarts at 0x0000.
REQ-038 pc_next=0x1235 retired -> pc_cur=0x1234; pc_next=0x0000 from pc_cur=0xFFFE -> pc_cur=0x0000.
